// File: rtl/tri_bbox_cull_pkg.sv
// Shared triangle-setup types: vertex/triangle layout, coordinate indices,
// the stage-3 setup record and small signed min/max/clamp helpers.
package tri_bbox_cull_pkg;

  localparam int X = 0;
  localparam int Y = 1;
  localparam int Z = 2;

  typedef logic [15:0]   coord_t;
  typedef coord_t [2:0]  vertex_t;
  typedef vertex_t [2:0] tri_t;

  // Bbox fields are wide enough for any viewport; the top trims them to port width.
  typedef struct packed {
    logic [15:0]        min_x;
    logic [15:0]        max_x;
    logic [15:0]        min_y;
    logic [15:0]        max_y;
    logic signed [34:0] area2;
    logic               empty;
  } tri_setup_t;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [15:0] clamp_coord(input logic signed [15:0] v, input int limit);
    if (v < 0) return '0;
    if (int'(v) > limit - 1) return 16'(limit - 1);
    return v;
  endfunction

endpackage

// File: rtl/freezable_pipeline.sv
// DEPTH-stage register chain that shifts only while freeze is low; 
// sync reset clears every stage to zero.
module freezable_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else if (!freeze) begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/tri_bbox_cull_bbox_clamp.sv
// Clamps a signed 16-bit min/max pair into [0, LIMIT-1]; purely combinational.
module bbox_clamp #(
  parameter int LIMIT = 320
) (
  input  logic signed [15:0]         lo,
  input  logic signed [15:0]         hi,
  output logic [$clog2(LIMIT)-1:0]   lo_clamped,
  output logic [$clog2(LIMIT)-1:0]   hi_clamped
);
  import tri_bbox_cull_pkg::*;

  localparam int OW = $clog2(LIMIT);

  assign lo_clamped = OW'(clamp_coord(lo, LIMIT));
  assign hi_clamped = OW'(clamp_coord(hi, LIMIT));

endmodule

// File: rtl/tri_bbox_cull.sv
// Triangle setup: bbox, doubled area and cull; 3-cycle latency, 1 tri/cycle.
// Whole pipe freezes when stage 3 holds a beat that downstream is not taking.
module tri_bbox_cull #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 180,
  parameter int TRI_COUNT     = 2048,
  parameter int BACKFACE_CULL = 1,
  parameter int TRI_ID_WIDTH  = $clog2(TRI_COUNT)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [2:0][2:0][15:0]      tri_vertices_in,
  input  logic                       last_tri_in,
  input  logic [TRI_ID_WIDTH-1:0]    tri_id_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [2:0][2:0][15:0]      tri_vertices_out,
  output logic [TRI_ID_WIDTH-1:0]    tri_id_out,
  output logic                       last_tri_out,
  output logic                       empty_out,
  output logic [$clog2(WIDTH)-1:0]   bbox_min_x_out,
  output logic [$clog2(WIDTH)-1:0]   bbox_max_x_out,
  output logic [$clog2(HEIGHT)-1:0]  bbox_min_y_out,
  output logic [$clog2(HEIGHT)-1:0]  bbox_max_y_out,
  output logic signed [34:0]         area2_out,
  output logic [TRI_ID_WIDTH:0]      culled_count_out
);
  import tri_bbox_cull_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef struct packed {
    tri_t                    verts;
    logic [TRI_ID_WIDTH-1:0] id;
    logic                    last;
  } sideband_t;

  logic advance;
  logic s1_valid, s2_valid, s3_valid;
  logic signed [15:0] x0, x1, x2, y0, y1, y2;
  logic signed [15:0] s1_min_x, s1_max_x, s1_min_y, s1_max_y;
  logic signed [15:0] s2_min_x, s2_max_x, s2_min_y, s2_max_y;
  logic signed [16:0] s1_dx1, s1_dy1, s1_dx2, s1_dy2;
  logic signed [33:0] s2_p0, s2_p1;
  logic signed [34:0] area2_next;
  logic offscreen, cull, count_inc, last_hs;
  logic [XW-1:0] cx_lo, cx_hi;
  logic [YW-1:0] cy_lo, cy_hi;
  tri_setup_t setup_next, s3_setup;
  sideband_t sb_in, sb1, sb2, sb3;
  logic [TRI_ID_WIDTH:0] culled_count;

  assign advance   = !s3_valid || ready_in;
  assign ready_out = advance;

  assign x0 = tri_vertices_in[0][X];
  assign x1 = tri_vertices_in[1][X];
  assign x2 = tri_vertices_in[2][X];
  assign y0 = tri_vertices_in[0][Y];
  assign y1 = tri_vertices_in[1][Y];
  assign y2 = tri_vertices_in[2][Y];

  assign sb_in = '{verts: tri_vertices_in, id: tri_id_in, last: last_tri_in};

  freezable_pipeline #(.WIDTH($bits(sideband_t)), .DEPTH(1)) u_sb1 (
    .clk(clk_in), .rst(rst_in), .freeze(!advance), .d(sb_in), .q(sb1));
  freezable_pipeline #(.WIDTH($bits(sideband_t)), .DEPTH(1)) u_sb2 (
    .clk(clk_in), .rst(rst_in), .freeze(!advance), .d(sb1), .q(sb2));
  freezable_pipeline #(.WIDTH($bits(sideband_t)), .DEPTH(1)) u_sb3 (
    .clk(clk_in), .rst(rst_in), .freeze(!advance), .d(sb2), .q(sb3));

  bbox_clamp #(.LIMIT(WIDTH)) u_clamp_x (
    .lo(s2_min_x), .hi(s2_max_x), .lo_clamped(cx_lo), .hi_clamped(cx_hi));
  bbox_clamp #(.LIMIT(HEIGHT)) u_clamp_y (
    .lo(s2_min_y), .hi(s2_max_y), .lo_clamped(cy_lo), .hi_clamped(cy_hi));

  // Cull is resolved before the stage-3 register so a dropped triangle never shows up as valid.
  assign area2_next = 35'(s2_p0) - 35'(s2_p1);
  assign offscreen  = (s2_max_x < 0) || (int'(s2_min_x) > WIDTH - 1) ||
                      (s2_max_y < 0) || (int'(s2_min_y) > HEIGHT - 1);
  assign cull       = offscreen || (area2_next == '0) || (BACKFACE_CULL != 0 && area2_next < 0);
  assign count_inc  = advance && s2_valid && cull;
  assign last_hs    = s3_valid && ready_in && sb3.last;

  always_comb begin
    setup_next       = '0;
    setup_next.min_x = 16'(cx_lo);
    setup_next.max_x = 16'(cx_hi);
    setup_next.min_y = 16'(cy_lo);
    setup_next.max_y = 16'(cy_hi);
    setup_next.area2 = area2_next;
    setup_next.empty = cull;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_min_x <= '0; s1_max_x <= '0; s1_min_y <= '0; s1_max_y <= '0;
      s2_min_x <= '0; s2_max_x <= '0; s2_min_y <= '0; s2_max_y <= '0;
      s1_dx1 <= '0; s1_dy1 <= '0; s1_dx2 <= '0; s1_dy2 <= '0;
      s2_p0 <= '0; s2_p1 <= '0;
      s3_setup <= '0;
      culled_count <= '0;
    end else begin
      if (advance) begin
        s1_valid <= valid_in;
        s1_min_x <= min3(x0, x1, x2);
        s1_max_x <= max3(x0, x1, x2);
        s1_min_y <= min3(y0, y1, y2);
        s1_max_y <= max3(y0, y1, y2);
        s1_dx1   <= 17'(x1) - 17'(x0);
        s1_dy1   <= 17'(y1) - 17'(y0);
        s1_dx2   <= 17'(x2) - 17'(x0);
        s1_dy2   <= 17'(y2) - 17'(y0);
        s2_valid <= s1_valid;
        s2_min_x <= s1_min_x;
        s2_max_x <= s1_max_x;
        s2_min_y <= s1_min_y;
        s2_max_y <= s1_max_y;
        s2_p0    <= 34'(s1_dx1) * 34'(s1_dy2);
        s2_p1    <= 34'(s1_dx2) * 34'(s1_dy1);
        // A culled mesh-end still goes out as an empty beat so the marker is never lost.
        s3_valid <= s2_valid && (!cull || sb2.last);
        s3_setup <= setup_next;
      end
      if (last_hs) begin
        culled_count <= {{TRI_ID_WIDTH{1'b0}}, count_inc};
      end else if (count_inc && culled_count != '1) begin
        culled_count <= culled_count + 1'b1;
      end
    end
  end

  assign valid_out        = s3_valid;
  assign tri_vertices_out = sb3.verts;
  assign tri_id_out       = sb3.id;
  assign last_tri_out     = sb3.last;
  assign empty_out        = s3_setup.empty;
  assign bbox_min_x_out   = XW'(s3_setup.min_x);
  assign bbox_max_x_out   = XW'(s3_setup.max_x);
  assign bbox_min_y_out   = YW'(s3_setup.min_y);
  assign bbox_max_y_out   = YW'(s3_setup.max_y);
  assign area2_out        = s3_setup.area2;
  assign culled_count_out = culled_count;

endmodule

// File: tb/tb_tri_bbox_cull.sv
// Directed and randomized bench for tri_bbox_cull against a triangle-level reference model.
module tb_tri_bbox_cull;

  localparam int W   = 320;
  localparam int H   = 180;
  localparam int TIW = 11;

  logic                  clk_in = 1'b0;
  logic                  rst_in, valid_in, ready_out, last_tri_in;
  logic                  valid_out, ready_in, last_tri_out, empty_out;
  logic [2:0][2:0][15:0] tri_vertices_in, tri_vertices_out;
  logic [TIW-1:0]        tri_id_in, tri_id_out;
  logic [8:0]            bbox_min_x_out, bbox_max_x_out;
  logic [7:0]            bbox_min_y_out, bbox_max_y_out;
  logic signed [34:0]    area2_out;
  logic [TIW:0]          culled_count_out;

  always #5 clk_in = ~clk_in;

  tri_bbox_cull #(.WIDTH(W), .HEIGHT(H), .TRI_COUNT(2048), .BACKFACE_CULL(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .tri_vertices_in(tri_vertices_in), .last_tri_in(last_tri_in), .tri_id_in(tri_id_in),
    .valid_out(valid_out), .ready_in(ready_in), .tri_vertices_out(tri_vertices_out),
    .tri_id_out(tri_id_out), .last_tri_out(last_tri_out), .empty_out(empty_out),
    .bbox_min_x_out(bbox_min_x_out), .bbox_max_x_out(bbox_max_x_out),
    .bbox_min_y_out(bbox_min_y_out), .bbox_max_y_out(bbox_max_y_out),
    .area2_out(area2_out), .culled_count_out(culled_count_out));

  typedef struct {
    logic [2:0][2:0][15:0] v;
    logic [TIW-1:0]        id;
    logic                  last;
    logic                  empty;
    int                    minx, maxx, miny, maxy;
    longint                area;
    int                    cnt;
    int                    acc_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0, checks = 0, mesh_cull = 0, cyc = 0, beats = 0, last_lat = -1;
  logic         held = 1'b0;
  logic [225:0] held_snap;
  bit           a;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [225:0] snap();
    return {tri_vertices_out, tri_id_out, last_tri_out, empty_out, bbox_min_x_out,
            bbox_max_x_out, bbox_min_y_out, bbox_max_y_out, area2_out};
  endfunction

  function automatic int clampi(input int v, input int lim);
    return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
  endfunction

  function automatic logic [2:0][2:0][15:0] mk(input int x0, input int y0, input int x1,
                                               input int y1, input int x2, input int y2);
    logic [2:0][2:0][15:0] r;
    r[0][0] = 16'(x0); r[0][1] = 16'(y0); r[0][2] = 16'(x0 + 3);
    r[1][0] = 16'(x1); r[1][1] = 16'(y1); r[1][2] = 16'(y1 - 7);
    r[2][0] = 16'(x2); r[2][1] = 16'(y2); r[2][2] = 16'(x2 * 2);
    return r;
  endfunction

  // Reference: plain integer geometry on the accepted triangle.
  task automatic model_accept();
    exp_t e;
    int   x[3], y[3];
    int   mnx, mxx, mny, mxy;
    bit   cull;
    for (int i = 0; i < 3; i++) begin
      x[i] = int'($signed(tri_vertices_in[i][0]));
      y[i] = int'($signed(tri_vertices_in[i][1]));
    end
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    e.area = longint'(x[1] - x[0]) * longint'(y[2] - y[0]) - longint'(x[2] - x[0]) * longint'(y[1] - y[0]);
    cull = (mxx < 0) || (mnx > W - 1) || (mxy < 0) || (mny > H - 1) || (e.area <= 0);
    e.minx = clampi(mnx, W); e.maxx = clampi(mxx, W);
    e.miny = clampi(mny, H); e.maxy = clampi(mxy, H);
    e.v = tri_vertices_in; e.id = tri_id_in; e.last = last_tri_in; e.empty = cull;
    e.acc_cyc = cyc;
    if (cull) mesh_cull++;
    e.cnt = mesh_cull;
    if (last_tri_in) mesh_cull = 0;
    if (!cull || last_tri_in) exp_q.push_back(e);
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk_in);
    cyc++;
    if (rst_in) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", valid_out, 1);
        checks++;
        assert (snap() === held_snap) else begin
          errors++;
          $error("FAIL hold_payload: got %h expected %h", snap(), held_snap);
        end
      end
      if (valid_out) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_beat: got valid_out=1 id=%0d expected no pending triangle", tri_id_out);
        end
      end
      if (valid_out && ready_in && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        beats++;
        last_lat = cyc - e.acc_cyc;
        chk("out_id", tri_id_out, e.id);
        chk("out_last", last_tri_out, e.last);
        chk("out_empty", empty_out, e.empty);
        checks++;
        assert (tri_vertices_out === e.v) else begin
          errors++;
          $error("FAIL out_vertices: got %h expected %h", tri_vertices_out, e.v);
        end
        if (!e.empty) begin
          chk("bbox_min_x", bbox_min_x_out, e.minx);
          chk("bbox_max_x", bbox_max_x_out, e.maxx);
          chk("bbox_min_y", bbox_min_y_out, e.miny);
          chk("bbox_max_y", bbox_max_y_out, e.maxy);
          chk("area2", area2_out, e.area);
        end
        if (e.last) chk("count_at_last", culled_count_out, e.cnt);
      end
      if (valid_in && ready_out) begin
        model_accept();
        acc = 1'b1;
      end
      held      = valid_out && !ready_in;
      held_snap = snap();
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [2:0][2:0][15:0] t, input int id, input bit last);
    bit got;
    got = 1'b0;
    valid_in = 1'b1; tri_vertices_in = t; tri_id_in = TIW'(id); last_tri_in = last;
    for (int i = 0; i < 50 && !got; i++) tick(got);
    chk("send_accepted", got, 1);
    valid_in = 1'b0; last_tri_in = 1'b0;
  endtask

  task automatic drain();
    bit got;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(got);
    for (int i = 0; i < 5; i++) tick(got);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  function automatic logic [2:0][2:0][15:0] rand_tri();
    logic [2:0][2:0][15:0] r;
    int xs;
    xs = ($urandom_range(9) == 0) ? 400 : 0;
    for (int i = 0; i < 3; i++) begin
      r[i][0] = 16'(int'($urandom_range(560)) - 120 + xs);
      r[i][1] = 16'(int'($urandom_range(360)) - 90);
      r[i][2] = 16'($urandom);
    end
    if ($urandom_range(7) == 0) r[2] = r[1];
    return r;
  endfunction

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; last_tri_in = 1'b0;
    tri_vertices_in = '0; tri_id_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_count", culled_count_out, 0);
    chk("rst_area2", area2_out, 0);
    chk("rst_bbox_max_x", bbox_max_x_out, 0);
    chk("rst_tri_id", tri_id_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Basic triangle, unstalled latency.
    send(mk(10, 10, 50, 10, 10, 40), 5, 1'b0);
    drain();
    chk("t1_latency", last_lat, 3);
    chk("t1_beats", beats, 1);

    // Winding reversed: back-facing, dropped.
    send(mk(10, 10, 10, 40, 50, 10), 6, 1'b0);
    drain();
    chk("t2_no_beat", beats, 1);
    chk("t2_count", culled_count_out, mesh_cull);

    // Collinear mesh end: forwarded empty, counter cleared afterwards.
    send(mk(0, 0, 5, 5, 10, 10), 7, 1'b1);
    drain();
    chk("t3_beats", beats, 2);
    chk("t3_count_cleared", culled_count_out, 0);

    // Oversized triangle clamped to the viewport.
    send(mk(-20, -5, 400, -5, -20, 300), 8, 1'b0);
    drain();
    chk("t4_beats", beats, 3);

    // Back-to-back with a 5-cycle downstream stall.
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1; tri_vertices_in = mk(10 + k, 10, 50 + k, 10, 10 + k, 40);
      tri_id_in = TIW'(20 + k); last_tri_in = 1'b0;
      tick(a);
      chk("stall_pre_accept", a, 1);
    end
    tri_vertices_in = mk(13, 10, 53, 10, 13, 40); tri_id_in = TIW'(23);
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(a);
      chk("stall_no_accept", a, 0);
      chk("stall_ready_low", ready_out, 0);
    end
    ready_in = 1'b1;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) tick(a);
    chk("stall_last_accept", a, 1);
    valid_in = 1'b0;
    drain();
    chk("t5_beats", beats, 7);

    // Reset with two triangles in flight, after one culled triangle was counted.
    send(mk(10, 10, 10, 40, 50, 10), 30, 1'b0);
    drain();
    chk("t6_pre_count", culled_count_out, 1);
    valid_in = 1'b1; tri_vertices_in = mk(20, 20, 60, 20, 20, 50); tri_id_in = TIW'(31);
    tick(a);
    tri_vertices_in = mk(30, 30, 70, 30, 30, 60); tri_id_in = TIW'(32);
    tick(a);
    valid_in = 1'b0;
    rst_in = 1'b1;
    exp_q.delete();
    mesh_cull = 0;
    tick(a);
    chk("t6_valid_after_rst", valid_out, 0);
    chk("t6_count_after_rst", culled_count_out, 0);
    rst_in = 1'b0;
    drain();
    chk("t6_no_stale_beats", beats, 7);

    // Randomized traffic with random backpressure and mesh ends.
    a = 1'b0;
    valid_in = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!valid_in || a) begin
        if ($urandom_range(3) != 0) begin
          valid_in = 1'b1;
          tri_vertices_in = rand_tri();
          tri_id_in = TIW'($urandom);
          last_tri_in = ($urandom_range(9) == 0);
        end else begin
          valid_in = 1'b0;
          last_tri_in = 1'b0;
        end
      end
      ready_in = ($urandom_range(4) != 0);
      tick(a);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    drain();
    chk("rand_count_model", culled_count_out, mesh_cull);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
